// File: rtl/lsu_dccm_pkg.sv
// DCCM store-buffer package: build configuration, address decode helpers and
// the store-buffer entry layout shared by the data array top and its banks.
// Latency: n/a (types and pure functions only). Backpressure: n/a.
package lsu_dccm_pkg;

    // Build configuration; the entry struct and decode helpers are sized from these.
    localparam int DCCM_NUM_BANKS  = 8;
    localparam int DCCM_DATA_W     = 32;
    localparam int DCCM_INDEX_W    = 11;
    localparam int DCCM_WBUF_DEPTH = 4;
    localparam int DCCM_STARVE_MAX = 8;

    localparam int DCCM_BYTES     = DCCM_DATA_W / 8;
    localparam int DCCM_BW        = $clog2(DCCM_BYTES);
    localparam int DCCM_BANK_BITS = $clog2(DCCM_NUM_BANKS);
    localparam int DCCM_ADDR_W    = DCCM_BW + DCCM_BANK_BITS + DCCM_INDEX_W;

    typedef struct packed {
        logic [DCCM_BANK_BITS-1:0] bank;
        logic [DCCM_INDEX_W-1:0]   index;
        logic [DCCM_DATA_W-1:0]    data;
        logic [DCCM_BYTES-1:0]     be;
    } wbuf_entry_t;

    // Bank select sits directly above the byte offset so consecutive words
    // land in different banks.
    function automatic logic [DCCM_BANK_BITS-1:0] f_bank(input logic [DCCM_ADDR_W-1:0] addr);
        return addr[DCCM_BW +: DCCM_BANK_BITS];
    endfunction

    function automatic logic [DCCM_INDEX_W-1:0] f_index(input logic [DCCM_ADDR_W-1:0] addr);
        return addr[DCCM_BW + DCCM_BANK_BITS +: DCCM_INDEX_W];
    endfunction

endpackage

// File: rtl/lsu_dccm_bank.sv
// Single-port DCCM bank: byte-write, synchronous read, clock-enabled.
// Latency: read data on rdata one cycle after ce&~we; rdata holds otherwise.
// Backpressure: none; the caller guarantees one access per cycle.
// Ports: clk; ce (clock enable); we (write when ce); addr (word index);
//        wdata/be (write data and byte enables); rdata (registered read data).
// Behavioural array; the memory macro replaces this module in synthesis.
module lsu_dccm_bank
    import lsu_dccm_pkg::*;
#(
    parameter int DATA_W  = DCCM_DATA_W,
    parameter int INDEX_W = DCCM_INDEX_W
) (
    input  logic                  clk,
    input  logic                  ce,
    input  logic                  we,
    input  logic [INDEX_W-1:0]    addr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   be,
    output logic [DATA_W-1:0]     rdata
);

    localparam int BYTES = DATA_W / 8;

    logic [DATA_W-1:0] mem [2**INDEX_W];

    // Writes leave rdata untouched so a held read result survives a later drain.
    always_ff @(posedge clk) begin
        if (ce) begin
            if (we) begin
                for (int b = 0; b < BYTES; b++) begin
                    if (be[b]) begin
                        mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/lsu_dccm_wbuf_mem.sv
// Banked DCCM data array with an in-order store buffer and load forwarding.
// Latency: load accepted in cycle N returns rd_data_* in N+1; stores post in 1 cycle.
// Backpressure: wr_ready drops when full or frozen; rd_ready drops on freeze or starved head bank.
// Ports: clk, rst (async, active-high), freeze;
//        wr_valid/wr_ready/wr_addr/wr_data/wr_be   store request;
//        rd_valid/rd_ready/rd_addr_lo/rd_addr_hi   load request (hi == lo when aligned);
//        rd_data_valid/rd_data_lo/rd_data_hi       load result with forwarded bytes merged;
//        wbuf_count/wbuf_empty                     store buffer occupancy.
module lsu_dccm_wbuf_mem
    import lsu_dccm_pkg::*;
#(
    parameter int NUM_BANKS  = DCCM_NUM_BANKS,
    parameter int DATA_W     = DCCM_DATA_W,
    parameter int INDEX_W    = DCCM_INDEX_W,
    parameter int WBUF_DEPTH = DCCM_WBUF_DEPTH,
    parameter int STARVE_MAX = DCCM_STARVE_MAX,
    localparam int BYTES     = DATA_W / 8,
    localparam int BW        = $clog2(BYTES),
    localparam int BANK_BITS = $clog2(NUM_BANKS),
    localparam int ADDR_W    = BW + BANK_BITS + INDEX_W,
    localparam int CNT_W     = $clog2(WBUF_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 freeze,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [DATA_W-1:0]    wr_data,
    input  logic [BYTES-1:0]     wr_be,
    input  logic                 rd_valid,
    output logic                 rd_ready,
    input  logic [ADDR_W-1:0]    rd_addr_lo,
    input  logic [ADDR_W-1:0]    rd_addr_hi,
    output logic                 rd_data_valid,
    output logic [DATA_W-1:0]    rd_data_lo,
    output logic [DATA_W-1:0]    rd_data_hi,
    output logic [CNT_W-1:0]     wbuf_count,
    output logic                 wbuf_empty
);

    localparam int PTR_W = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
    localparam int ST_W  = $clog2(STARVE_MAX + 1);

    // The entry struct and decode helpers come from the package, so the
    // module parameters must agree with the package configuration.
    if (NUM_BANKS != DCCM_NUM_BANKS || DATA_W != DCCM_DATA_W || INDEX_W != DCCM_INDEX_W) begin : g_cfg_err
        $error("lsu_dccm_wbuf_mem parameters disagree with lsu_dccm_pkg configuration");
    end

    // ------------------------------------------------------------------
    // Store buffer state
    // ------------------------------------------------------------------
    wbuf_entry_t            entries [WBUF_DEPTH];
    wbuf_entry_t            head_e;
    wbuf_entry_t            wr_entry;
    logic [PTR_W-1:0]       head;
    logic [PTR_W-1:0]       tail;
    logic [CNT_W-1:0]       count;
    logic [ST_W-1:0]        starve_cnt;

    logic [BANK_BITS-1:0]   lo_bank;
    logic [BANK_BITS-1:0]   hi_bank;
    logic [INDEX_W-1:0]     lo_idx;
    logic [INDEX_W-1:0]     hi_idx;

    logic                   head_vld;
    logic                   full;
    logic                   head_hit;
    logic                   starve;
    logic                   rd_acc;
    logic                   wr_acc;
    logic                   drain;

    logic [DATA_W-1:0]      bank_q [NUM_BANKS];

    // Forwarding results, computed this cycle and registered with the load.
    logic [BYTES-1:0]       fwd_mask_lo_n;
    logic [BYTES-1:0]       fwd_mask_hi_n;
    logic [DATA_W-1:0]      fwd_data_lo_n;
    logic [DATA_W-1:0]      fwd_data_hi_n;
    logic [BYTES-1:0]       fwd_mask_lo;
    logic [BYTES-1:0]       fwd_mask_hi;
    logic [DATA_W-1:0]      fwd_data_lo;
    logic [DATA_W-1:0]      fwd_data_hi;
    logic [BANK_BITS-1:0]   lo_bank_r;
    logic [BANK_BITS-1:0]   hi_bank_r;

    // Byte-offset bits carry no information for word accesses.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{wr_addr[BW-1:0], rd_addr_lo[BW-1:0], rd_addr_hi[BW-1:0]};

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(WBUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // ------------------------------------------------------------------
    // Decode and arbitration
    // ------------------------------------------------------------------
    assign lo_bank = f_bank(rd_addr_lo);
    assign hi_bank = f_bank(rd_addr_hi);
    assign lo_idx  = f_index(rd_addr_lo);
    assign hi_idx  = f_index(rd_addr_hi);

    assign head_e   = entries[head];
    assign head_vld = (count != '0);
    assign full     = (count == CNT_W'(WBUF_DEPTH));
    assign head_hit = head_vld & ((head_e.bank == lo_bank) | (head_e.bank == hi_bank));
    assign starve   = (starve_cnt == ST_W'(STARVE_MAX));

    // A starved head wins its bank: loads touching it are held off this cycle.
    assign rd_ready = ~freeze & ~(starve & head_hit);
    assign rd_acc   = rd_valid & rd_ready;
    assign wr_ready = ~full & ~freeze;
    assign wr_acc   = wr_valid & wr_ready;
    // The head drains unless an accepted load owns its bank (single-port banks).
    assign drain    = head_vld & ~freeze & ~(rd_acc & head_hit);

    assign wbuf_count = count;
    assign wbuf_empty = ~head_vld;

    always_comb begin
        wr_entry       = '0;
        wr_entry.bank  = f_bank(wr_addr);
        wr_entry.index = f_index(wr_addr);
        wr_entry.data  = wr_data;
        wr_entry.be    = wr_be;
    end

    // ------------------------------------------------------------------
    // Pointers, occupancy, starvation, load-valid
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            starve_cnt    <= '0;
            rd_data_valid <= 1'b0;
        end else if (!freeze) begin
            if (wr_acc) begin
                tail <= ptr_inc(tail);
            end
            if (drain) begin
                head <= ptr_inc(head);
            end
            // A slot freed by a drain is only reusable next cycle because
            // wr_ready was computed from this cycle's count.
            count <= count + CNT_W'(wr_acc) - CNT_W'(drain);
            if (drain || !head_vld) begin
                starve_cnt <= '0;
            end else if (rd_acc && head_hit) begin
                starve_cnt <= starve_cnt + ST_W'(1);
            end
            rd_data_valid <= rd_acc;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            entries[tail] <= wr_entry;
        end
    end

    // ------------------------------------------------------------------
    // Byte forwarding: walk oldest to youngest so younger entries overwrite.
    // A draining head cannot match an accepted load (it targets a non-read
    // bank), so no explicit exclusion is needed.
    // ------------------------------------------------------------------
    always_comb begin
        logic [PTR_W:0] pos;
        wbuf_entry_t    e;
        fwd_mask_lo_n = '0;
        fwd_mask_hi_n = '0;
        fwd_data_lo_n = '0;
        fwd_data_hi_n = '0;
        pos           = '0;
        e             = '0;
        for (int k = 0; k < WBUF_DEPTH; k++) begin
            pos = {1'b0, head} + (PTR_W+1)'(k);
            if (pos >= (PTR_W+1)'(WBUF_DEPTH)) begin
                pos = pos - (PTR_W+1)'(WBUF_DEPTH);
            end
            e = entries[pos[PTR_W-1:0]];
            if (CNT_W'(k) < count) begin
                for (int b = 0; b < BYTES; b++) begin
                    if (e.be[b] && e.bank == lo_bank && e.index == lo_idx) begin
                        fwd_mask_lo_n[b]        = 1'b1;
                        fwd_data_lo_n[b*8 +: 8] = e.data[b*8 +: 8];
                    end
                    if (e.be[b] && e.bank == hi_bank && e.index == hi_idx) begin
                        fwd_mask_hi_n[b]        = 1'b1;
                        fwd_data_hi_n[b*8 +: 8] = e.data[b*8 +: 8];
                    end
                end
            end
        end
    end

    // Captured only on an accepted load, so freeze leaves them untouched.
    always_ff @(posedge clk) begin
        if (rd_acc) begin
            fwd_mask_lo <= fwd_mask_lo_n;
            fwd_mask_hi <= fwd_mask_hi_n;
            fwd_data_lo <= fwd_data_lo_n;
            fwd_data_hi <= fwd_data_hi_n;
            lo_bank_r   <= lo_bank;
            hi_bank_r   <= hi_bank;
        end
    end

    // ------------------------------------------------------------------
    // Banks
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        logic               wr_hit;
        logic               rd_lo_hit;
        logic               rd_hit;
        logic               ce;
        logic [INDEX_W-1:0] addr;

        assign wr_hit    = drain & (head_e.bank == BANK_BITS'(g));
        assign rd_lo_hit = lo_bank == BANK_BITS'(g);
        assign rd_hit    = rd_acc & (rd_lo_hit | (hi_bank == BANK_BITS'(g)));
        assign ce        = (wr_hit | rd_hit) & ~freeze;
        // When lo and hi share a bank they share the index too (aligned load).
        assign addr      = wr_hit ? head_e.index : (rd_lo_hit ? lo_idx : hi_idx);

        lsu_dccm_bank #(
            .DATA_W  (DATA_W),
            .INDEX_W (INDEX_W)
        ) u_bank (
            .clk   (clk),
            .ce    (ce),
            .we    (wr_hit),
            .addr  (addr),
            .wdata (head_e.data),
            .be    (head_e.be),
            .rdata (bank_q[g])
        );
    end

    // ------------------------------------------------------------------
    // Read-data merge
    // ------------------------------------------------------------------
    always_comb begin
        rd_data_lo = bank_q[lo_bank_r];
        rd_data_hi = bank_q[hi_bank_r];
        for (int b = 0; b < BYTES; b++) begin
            if (fwd_mask_lo[b]) begin
                rd_data_lo[b*8 +: 8] = fwd_data_lo[b*8 +: 8];
            end
            if (fwd_mask_hi[b]) begin
                rd_data_hi[b*8 +: 8] = fwd_data_hi[b*8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_lsu_dccm_wbuf_mem.sv
// Bench for lsu_dccm_wbuf_mem: directed scenarios plus a random mix, with a
// byte-level memory model feeding a scoreboard of expected load results.
module tb_lsu_dccm_wbuf_mem;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        rd_valid;
    logic        rd_ready;
    logic [15:0] rd_addr_lo;
    logic [15:0] rd_addr_hi;
    logic        rd_data_valid;
    logic [31:0] rd_data_lo;
    logic [31:0] rd_data_hi;
    logic [2:0]  wbuf_count;
    logic        wbuf_empty;

    int checks = 0;
    int errors = 0;

    lsu_dccm_wbuf_mem dut (
        .clk           (clk),
        .rst           (rst),
        .freeze        (freeze),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_be         (wr_be),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .rd_addr_lo    (rd_addr_lo),
        .rd_addr_hi    (rd_addr_hi),
        .rd_data_valid (rd_data_valid),
        .rd_data_lo    (rd_data_lo),
        .rd_data_hi    (rd_data_hi),
        .wbuf_count    (wbuf_count),
        .wbuf_empty    (wbuf_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    // ---------------- scoreboard / architectural memory model ----------------
    logic [31:0] mem_m [logic [13:0]];
    logic [63:0] exp_q [$];
    logic [63:0] last_exp = '0;
    logic        rdv_exp  = 1'b0;
    logic        prev_acc = 1'b0;
    logic        prev_frz = 1'b0;

    function automatic logic [31:0] mem_rd(input logic [15:0] a);
        return mem_m.exists(a[15:2]) ? mem_m[a[15:2]] : 32'h0;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            rdv_exp  = 1'b0;
            prev_acc = 1'b0;
            prev_frz = 1'b0;
        end else begin
            // Result of last cycle's load (held while frozen).
            if (!prev_frz) begin
                rdv_exp = prev_acc;
                if (prev_acc) begin
                    if (exp_q.size() == 0) chk("sb_underflow", 1, 0);
                    else last_exp = exp_q.pop_front();
                end
            end
            chk("rd_data_valid", rd_data_valid, rdv_exp);
            if (rdv_exp) begin
                chk("rd_data_lo", rd_data_lo, last_exp[31:0]);
                chk("rd_data_hi", rd_data_hi, last_exp[63:32]);
            end
            // This cycle's acceptances: load sees stores accepted before it only.
            prev_frz = freeze;
            prev_acc = rd_valid & rd_ready;
            if (prev_acc) exp_q.push_back({mem_rd(rd_addr_hi), mem_rd(rd_addr_lo)});
            if (wr_valid & wr_ready) begin
                logic [31:0] w;
                w = mem_rd(wr_addr);
                for (int b = 0; b < 4; b++) if (wr_be[b]) w[b*8 +: 8] = wr_data[b*8 +: 8];
                mem_m[wr_addr[15:2]] = w;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic wv, input logic [15:0] wa, input logic [31:0] wd, input logic [3:0] wbe,
                       input logic rv, input logic [15:0] lo, input logic [15:0] hi);
        wr_valid   = wv;
        wr_addr    = wa;
        wr_data    = wd;
        wr_be      = wbe;
        rd_valid   = rv;
        rd_addr_lo = lo;
        rd_addr_hi = hi;
    endtask

    task automatic idle();
        drv(0, 16'h0, 32'h0, 4'h0, 0, 16'h0, 16'h0);
    endtask

    task automatic wait_empty();
        int n = 0;
        while (!wbuf_empty && n < 64) begin
            tick();
            n++;
        end
        chk("drain_timeout", wbuf_empty, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        rst    = 1'b1;
        freeze = 1'b0;
        idle();
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_count", wbuf_count, 0);
        chk("rst_empty", wbuf_empty, 1);
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_rd_ready", rd_ready, 1);
        chk("rst_rdv", rd_data_valid, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        // 1: store then drain with no reads, load back.
        drv(1, 16'h1000, 32'hAABBCCDD, 4'hF, 0, 16'h0, 16'h0);
        tick();
        idle();
        chk("t1_count_after_store", wbuf_count, 1);
        tick();
        chk("t1_empty_2cyc", wbuf_empty, 1);
        drv(0, 16'h0, 32'h0, 4'h0, 1, 16'h1000, 16'h1000);
        tick();
        idle();
        @(negedge clk);
        chk("t1_load", rd_data_lo, 32'hAABBCCDD);
        tick();

        // 2: partial store forwarded over bank contents.
        drv(1, 16'h2000, 32'h55667788, 4'hF, 0, 16'h0, 16'h0);
        tick();
        idle();
        wait_empty();
        drv(1, 16'h2000, 32'h00001234, 4'h3, 0, 16'h0, 16'h0);
        tick();
        drv(0, 16'h0, 32'h0, 4'h0, 1, 16'h2000, 16'h2000);
        tick();
        idle();
        @(negedge clk);
        chk("t2_fwd_lo", rd_data_lo, 32'h55661234);
        chk("t2_fwd_hi", rd_data_hi, 32'h55661234);
        tick();
        wait_empty();

        // 3: youngest entry wins, bank 0 kept busy so both stores stay buffered.
        drv(1, 16'h3000, 32'h11111111, 4'hF, 1, 16'h1000, 16'h1000);
        tick();
        drv(1, 16'h3000, 32'h00000022, 4'h1, 1, 16'h1000, 16'h1000);
        tick();
        drv(0, 16'h0, 32'h0, 4'h0, 1, 16'h3000, 16'h3000);
        @(negedge clk);
        chk("t3_count2", wbuf_count, 2);
        tick();
        idle();
        @(negedge clk);
        chk("t3_youngest", rd_data_lo, 32'h11111122);
        tick();
        wait_empty();

        // 4: misaligned lo/hi across banks 7 and 0.
        drv(1, 16'h101C, 32'hDEADBEEF, 4'hF, 0, 16'h0, 16'h0);
        tick();
        drv(1, 16'h1020, 32'h0BADF00D, 4'hF, 0, 16'h0, 16'h0);
        tick();
        idle();
        wait_empty();
        drv(1, 16'h1040, 32'hCAFEBABE, 4'hF, 1, 16'h101C, 16'h1020);
        tick();
        drv(0, 16'h0, 32'h0, 4'h0, 1, 16'h101C, 16'h1020);
        @(negedge clk);
        chk("t4_mis_lo", rd_data_lo, 32'hDEADBEEF);
        chk("t4_mis_hi", rd_data_hi, 32'h0BADF00D);
        tick();
        chk("t4_held_1", wbuf_count, 1);
        tick();
        chk("t4_held_2", wbuf_count, 1);
        idle();
        tick();
        chk("t4_drained", wbuf_count, 0);
        wait_empty();

        // 5: starvation preempts loads to the head bank after 8 blocked cycles.
        drv(1, 16'h2000, 32'h99999999, 4'hF, 1, 16'h1000, 16'h1000);
        tick();
        drv(0, 16'h0, 32'h0, 4'h0, 1, 16'h1000, 16'h1000);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("t5_rd_ready_blocked", rd_ready, 1);
            tick();
        end
        @(negedge clk);
        chk("t5_starve_rd_ready", rd_ready, 0);
        tick();
        @(negedge clk);
        chk("t5_after_rd_ready", rd_ready, 1);
        chk("t5_after_count", wbuf_count, 0);
        tick();
        idle();
        wait_empty();

        // 6: fill the buffer, reset while draining.
        drv(1, 16'h4000, 32'h01010101, 4'hF, 1, 16'h1000, 16'h1000);
        tick();
        drv(1, 16'h4020, 32'h02020202, 4'hF, 1, 16'h1000, 16'h1000);
        tick();
        drv(1, 16'h4040, 32'h03030303, 4'hF, 1, 16'h1000, 16'h1000);
        tick();
        drv(1, 16'h4060, 32'h04040404, 4'hF, 1, 16'h1000, 16'h1000);
        tick();
        drv(0, 16'h0, 32'h0, 4'h0, 1, 16'h101C, 16'h101C);
        @(negedge clk);
        chk("t6_full_wr_ready", wr_ready, 0);
        chk("t6_full_count", wbuf_count, 4);
        tick();
        idle();
        chk("t6_mid_drain_count", wbuf_count, 3);
        chk("t6_rdv_before_rst", rd_data_valid, 1);
        rst = 1'b1;
        #1;
        chk("t6_rst_count", wbuf_count, 0);
        chk("t6_rst_rdv", rd_data_valid, 0);
        chk("t6_rst_wr_ready", wr_ready, 1);
        chk("t6_rst_empty", wbuf_empty, 1);
        tick();
        rst = 1'b0;
        tick();

        // 7: freeze holds the load result and the buffer.
        drv(1, 16'h5000, 32'h77777777, 4'hF, 1, 16'h1000, 16'h1000);
        tick();
        drv(0, 16'h0, 32'h0, 4'h0, 1, 16'h1000, 16'h1000);
        tick();
        idle();
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t7_frz_rdv", rd_data_valid, 1);
            chk("t7_frz_lo", rd_data_lo, 32'hAABBCCDD);
            chk("t7_frz_count", wbuf_count, 1);
            chk("t7_frz_wr_ready", wr_ready, 0);
            chk("t7_frz_rd_ready", rd_ready, 0);
            tick();
        end
        freeze = 1'b0;
        wait_empty();

        // Random mix over a pre-initialised pool.
        for (int i = 0; i < 16; i++) begin
            drv(1, 16'h6000 + 16'(i * 4), $urandom, 4'hF, 0, 16'h0, 16'h0);
            tick();
        end
        idle();
        wait_empty();
        for (int c = 0; c < 300; c++) begin
            int li;
            logic [15:0] lo;
            li = $urandom_range(0, 14);
            lo = 16'h6000 + 16'(li * 4);
            drv(1'($urandom_range(0, 1)), 16'h6000 + 16'($urandom_range(0, 15) * 4), $urandom,
                4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), lo,
                ($urandom_range(0, 1) == 1) ? lo + 16'h4 : lo);
            freeze = ($urandom_range(0, 9) == 0);
            tick();
        end
        freeze = 1'b0;
        idle();
        wait_empty();
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
